// File: rtl/shift_link_pkg.sv
// -----------------------------------------------------------------------------
// shift_link_pkg
// Shared definitions for the serial shift-register link controller:
//   - FSM state encodings (IDLE / SHIFT / DONE)
//   - cnt_width(): width of a counter that must hold values 0..n-1
// Optional build macro used by the controller: SHIFT_LINK_CHECK_EN
// -----------------------------------------------------------------------------
package shift_link_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Bits needed to represent every value in 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_link_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_link_bit_counter
// Per-transfer bit counter for the shift link. Counts 0..DATA_W+DEPTH-1 while
// enabled; terminal flags the last count of a transfer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        synchronous clear to zero (priority over enable)
//   enable       advance by one
//   cnt          current count
//   terminal     cnt equals DATA_W+DEPTH-1
// -----------------------------------------------------------------------------
module shift_link_bit_counter
  import shift_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = cnt_width(DATA_W + DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  localparam int LAST = DATA_W + DEPTH - 1;

  // Count register: clear wins over enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign terminal = (cnt == CNT_W'(LAST));

endmodule

// File: rtl/shift_reg_link_ctrl.sv
// -----------------------------------------------------------------------------
// shift_reg_link_ctrl
// Sequencer for a DEPTH-stage serial-in/serial-out shift register. Accepts a
// parallel word, shifts it out LSB-first on ser_out followed by DEPTH zero
// flush bits, captures the bits returning on ser_in and presents the received
// word with a one-cycle rsp_valid strobe.
// Optional build macro: SHIFT_LINK_CHECK_EN adds rsp_err (loopback compare).
// Ports:
//   CLK, RST_n           clock, async active-low reset
//   req_valid/ready/data request handshake and word to send
//   abort                cancels an in-flight transfer (SHIFT only)
//   ser_out              to shift_in of the register
//   ser_in               from shift_out of the register
//   busy                 transfer in progress (SHIFT or DONE)
//   rsp_valid, rsp_data  one-cycle response strobe and received word
//   rsp_err              (SHIFT_LINK_CHECK_EN) received word != sent word
// -----------------------------------------------------------------------------
module shift_reg_link_ctrl
  import shift_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic              abort,
  output logic              ser_out,
  input  logic              ser_in,
  output logic              busy,
  output logic              rsp_valid,
`ifdef SHIFT_LINK_CHECK_EN
  output logic              rsp_err,
`endif
  output logic [DATA_W-1:0] rsp_data
);

  localparam int CNT_W = cnt_width(DATA_W + DEPTH);

  state_t              state_r;
  logic [DATA_W-1:0]   tx_r;       // remaining bits to send, shifted right each count
  logic [DATA_W-1:0]   rx_r;       // captured bits, filled from the MSB end
  logic [DATA_W-1:0]   rx_next_s;
  logic [DATA_W:0]     rx_cat_s;
  logic [CNT_W-1:0]    cnt_s;
  logic                term_s;
  logic                capture_s;
  logic                accept_s;
  logic                cnt_clear_s;
  logic                cnt_en_s;

  assign accept_s    = (state_r == IDLE) && req_valid && req_ready;
  assign cnt_en_s    = (state_r == SHIFT);
  assign cnt_clear_s = (state_r != SHIFT) || abort || term_s;

  // Bits on ser_in become valid once the first sent bit has crossed the
  // register, i.e. from count DEPTH onward.
  assign capture_s   = (cnt_s >= CNT_W'(DEPTH));

  // Shift the new bit in at the MSB; after DATA_W captures bit 0 sits at LSB.
  assign rx_cat_s    = {ser_in, rx_r};
  assign rx_next_s   = rx_cat_s[DATA_W:1];

  shift_link_bit_counter #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst_n    (RST_n),
    .clear    (cnt_clear_s),
    .enable   (cnt_en_s),
    .cnt      (cnt_s),
    .terminal (term_s)
  );

  // Transfer FSM with registered handshake, serial and response outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      ser_out   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tx_r      <= '0;
      rx_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept_s) begin
            // Bit 0 goes out during count 0; the rest queue in tx_r and
            // zeros shift in behind them to form the flush.
            ser_out   <= req_data[0];
            tx_r      <= req_data >> 1;
            rx_r      <= '0;
            state_r   <= SHIFT;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else begin
            ser_out   <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_r   <= IDLE;
            ser_out   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            if (capture_s) begin
              rx_r <= rx_next_s;
            end else begin
              rx_r <= rx_r;
            end
            if (term_s) begin
              state_r   <= DONE;
              ser_out   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= rx_next_s;
            end else begin
              ser_out   <= tx_r[0];
              tx_r      <= tx_r >> 1;
            end
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          ser_out   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_LINK_CHECK_EN
  logic [DATA_W-1:0] tx_word_r;   // unshifted copy of the sent word

  // Hold the sent word for the loopback compare.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tx_word_r <= '0;
    end else if (accept_s) begin
      tx_word_r <= req_data;
    end else begin
      tx_word_r <= tx_word_r;
    end
  end

  // Error flag is only ever high alongside rsp_valid.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rsp_err <= 1'b0;
    end else if ((state_r == SHIFT) && !abort && term_s) begin
      rsp_err <= (rx_next_s != tx_word_r);
    end else begin
      rsp_err <= 1'b0;
    end
  end
`else
  // Loopback compare not built in this configuration.
`endif

endmodule
